regfile_mp: RTL and testbench
=============================

// Module: regfile_mp
// PURPOSE
//  Parametrised multi-read-port register file for the MIPS datapath. It replaces the fixed 32x32 2-read file.
//  Adds a configurable read-port count, an optional hard-wired zero register and optional write-to-read bypass.
//  Adds a sequenced clear, which sweeps one entry per clock after reset or a clear request.
//  Sits between the decode stage (read addresses) and the writeback stage (write port).
// PARAMETERS
//  WIDTH    32  data width per register, bits
//  DEPTH    32  number of registers; power of two, >= 2
//  NUM_RD   2   number of independent combinational read ports, >= 1
//  R0_ZERO  1   1: entry 0 always reads 0 and writes to it are discarded
//  BYPASS   1   1: a same-cycle write is forwarded to matching read ports
//  Derived: AW = $clog2(DEPTH)
// PORTS
//  clock  in   1             rising-edge clock
//  reset  in   1             synchronous, active-high reset
//  clear  in   1             soft clear request; level-sampled in READY only
//  we     in   1             write enable
//  wa     in   AW            write address
//  wd     in   WIDTH         write data
//  ra     in   NUM_RD*AW     read addresses; port p = ra[p*AW +: AW]
//  rd     out  NUM_RD*WIDTH  read data; port p = rd[p*WIDTH +: WIDTH]
//  busy   out  1             1 while the clear sweep is in progress
// BEHAVIOUR
//  - FSM has two states, ST_CLEAR and ST_READY. The clear pointer cnt is AW bits wide.
//  - Reset (sampled at posedge): state<=ST_CLEAR, cnt<=0, busy<=1. Array contents are not touched in the reset cycle.
//  - ST_CLEAR, each clock: rf[cnt]<=0 and cnt<=cnt+1.
//    When cnt==DEPTH-1, state<=ST_READY and busy<=0.
//    busy is therefore high for exactly DEPTH clocks after the reset deassert edge.
//  - Reset mid-sweep restarts the sweep from cnt=0. The total is again DEPTH clocks.
//  - ST_READY with clear=1: state<=ST_CLEAR, cnt<=0, busy<=1. If we is also asserted that cycle, the write is dropped (clear wins).
//  - ST_READY with clear=0 and we=1: rf[wa]<=wd. If R0_ZERO=1 and wa==0, the write is discarded.
//  - In ST_CLEAR, we and clear are ignored.
//  - Reads are combinational, with zero latency. For each port p:
//      busy=1                                        -> rd_p = 0
//      R0_ZERO && ra_p==0                            -> rd_p = 0
//      BYPASS && we && !clear && wa==ra_p
//        && !(R0_ZERO && wa==0)                      -> rd_p = wd
//      otherwise                                     -> rd_p = rf[ra_p]
//  - With BYPASS=0, a written value is visible on the clock after the write edge.
//  - Reset values: busy=1 and all rd=0, both held until the sweep completes.
//  - Several read ports may use the same address. Each port evaluates independently.
//  - There is no X propagation. The initial-block preload is not used; the sweep is the only init mechanism.
// STRUCTURE
//  - The shared package mips_pkg holds:
//    - the state encodings RF_ST_CLEAR=1'b0 and RF_ST_READY=1'b1;
//    - the defaults RF_WIDTH=32 and RF_DEPTH=32.
//  - Sub-module rf_read_port(WIDTH,AW,R0_ZERO,BYPASS) contains the array-select, zero and bypass mux for one port.
//    It is instantiated NUM_RD times in a generate loop.
//  - The top level holds the storage array, the FSM, cnt and the write logic.
// TESTING
//  1. Reset for 3 clocks, then release.
//     Required: busy=1 for exactly 32 clocks, rd=0 throughout, then busy=0.
//     Every entry reads 0; in the sim, entries are preloaded with 0xDEADBEEF before reset to prove the sweep.
//  2. READY: write wa=5 wd=0x12345678 while ra0=5 in the same cycle.
//     Required: with BYPASS=1, rd0=0x12345678 in that cycle. With BYPASS=0, rd0=old value, then 0x12345678 next cycle.
//  3. Write wa=0 wd=0xFFFFFFFF with R0_ZERO=1.
//     Required: ra0=0 reads 0 in the write cycle and afterwards. With R0_ZERO=0, 0xFFFFFFFF is read back.
//  4. Assert clear and we (wa=7 wd=0xA5A5A5A5) together.
//     Required: the write is dropped, busy=1 for DEPTH clocks, and rf[7] reads 0 afterwards.
//  5. Assert reset at sweep cycle 10.
//     Required: the sweep restarts, busy falls exactly DEPTH clocks after the reset release, and writes during busy are ignored.
//  6. NUM_RD=4, DEPTH=64, WIDTH=16: fill all entries with their address, then drive 4 distinct ra values per cycle.
//     Required: each port returns its own address value, and a duplicate ra returns the same value on both ports.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS datapath constants: register-file FSM encodings and default geometry.
package mips_pkg;

  localparam logic [0:0] RF_ST_CLEAR = 1'b0;
  localparam logic [0:0] RF_ST_READY = 1'b1;

  localparam int RF_WIDTH = 32;
  localparam int RF_DEPTH = 32;

endpackage

// File: rtl/rf_read_port.sv
// One combinational read port: array select, hard-wired zero entry and write bypass.
module rf_read_port #(
  parameter int WIDTH   = 32,
  parameter int AW      = 5,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1
) (
  input  logic                            busy,
  input  logic                            we,
  input  logic                            clear,
  input  logic [AW-1:0]                   wa,
  input  logic [WIDTH-1:0]                wd,
  input  logic [(2**AW)-1:0][WIDTH-1:0]   rf,
  input  logic [AW-1:0]                   ra,
  output logic [WIDTH-1:0]                rd
);

  logic wa_is_zero;
  logic ra_is_zero;

  assign wa_is_zero = (wa == '0) && (R0_ZERO != 0);
  assign ra_is_zero = (ra == '0) && (R0_ZERO != 0);

  // Priority lowest-first: later assignments override earlier ones.
  always_comb begin
    rd = rf[ra];
    if ((BYPASS != 0) && we && !clear && (wa == ra) && !wa_is_zero) rd = wd;
    if (ra_is_zero) rd = '0;
    if (busy) rd = '0;
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with sequenced clear sweep after reset or on request.
//   state        | meaning
//   RF_ST_CLEAR  | sweeping one entry per clock to zero, reads forced to 0
//   RF_ST_READY  | normal operation, writes accepted
module regfile_mp
  import mips_pkg::*;
#(
  parameter int WIDTH   = RF_WIDTH,
  parameter int DEPTH   = RF_DEPTH,
  parameter int NUM_RD  = 2,
  parameter int R0_ZERO = 1,
  parameter int BYPASS  = 1,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    clear,
  input  logic                    we,
  input  logic [AW-1:0]           wa,
  input  logic [WIDTH-1:0]        wd,
  input  logic [NUM_RD*AW-1:0]    ra,
  output logic [NUM_RD*WIDTH-1:0] rd,
  output logic                    busy
);

  logic [0:0]                   state_q, state_d;
  logic [AW-1:0]                cnt_q, cnt_d;
  logic                         busy_q, busy_d;
  logic [DEPTH-1:0][WIDTH-1:0]  rf_q, rf_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    rf_d    = rf_q;
    case (state_q)
      RF_ST_CLEAR: begin
        rf_d[cnt_q] = '0;
        cnt_d       = cnt_q + AW'(1);
        if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = RF_ST_READY;
          busy_d  = 1'b0;
        end
      end
      default: begin
        // A clear request wins over a simultaneous write.
        if (clear) begin
          state_d = RF_ST_CLEAR;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end else if (we && !((R0_ZERO != 0) && (wa == '0))) begin
          rf_d[wa] = wd;
        end
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= RF_ST_CLEAR;
      cnt_q   <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage is left untouched during reset; the sweep is the only initialisation.
  always_ff @(posedge clock) begin
    if (!reset) rf_q <= rf_d;
  end

  assign busy = busy_q;

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    rf_read_port #(
      .WIDTH   (WIDTH),
      .AW      (AW),
      .R0_ZERO (R0_ZERO),
      .BYPASS  (BYPASS)
    ) u_rd_port (
      .busy  (busy_q),
      .we    (we),
      .clear (clear),
      .wa    (wa),
      .wd    (wd),
      .rf    (rf_q),
      .ra    (ra[p*AW +: AW]),
      .rd    (rd[p*WIDTH +: WIDTH])
    );
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for regfile_mp: a default 32x32 instance and a 64x16 4-port instance without zero/bypass.
module tb_regfile_mp;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic        rst_a, clr_a, we_a, busy_a;
  logic [4:0]  wa_a;
  logic [31:0] wd_a;
  logic [9:0]  ra_a;
  logic [63:0] rd_a;

  logic        rst_b2, clr_b, we_b, busy_b;
  logic [5:0]  wa_b;
  logic [15:0] wd_b;
  logic [23:0] ra_b;
  logic [63:0] rd_b;

  regfile_mp #(.WIDTH(32), .DEPTH(32), .NUM_RD(2), .R0_ZERO(1), .BYPASS(1)) u_dut_a (
    .clock(clock), .reset(rst_a), .clear(clr_a), .we(we_a), .wa(wa_a), .wd(wd_a),
    .ra(ra_a), .rd(rd_a), .busy(busy_a)
  );

  regfile_mp #(.WIDTH(16), .DEPTH(64), .NUM_RD(4), .R0_ZERO(0), .BYPASS(0)) u_dut_b (
    .clock(clock), .reset(rst_b2), .clear(clr_b), .we(we_b), .wa(wa_b), .wd(wd_b),
    .ra(ra_b), .rd(rd_b), .busy(busy_b)
  );

  int n_chk = 0;
  int n_pass = 0;
  bit chk_on = 0;

  // Reference model: array contents plus number of sweep clocks still to go.
  logic [31:0] m_a [32];
  logic [15:0] m_b [64];
  int left_a = 32;
  int left_b = 64;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  function automatic logic [31:0] exp_a(input logic [4:0] ra);
    if (left_a > 0) return 32'h0;
    if (ra == 5'd0) return 32'h0;
    if (we_a && !clr_a && wa_a == ra) return wd_a;
    return m_a[ra];
  endfunction

  function automatic logic [15:0] exp_b(input logic [5:0] ra);
    if (left_b > 0) return 16'h0;
    return m_b[ra];
  endfunction

  task automatic model_edge();
    if (rst_a) left_a = 32;
    else if (left_a > 0) begin m_a[32 - left_a] = 32'h0; left_a--; end
    else if (clr_a) left_a = 32;
    else if (we_a && wa_a != 5'd0) m_a[wa_a] = wd_a;

    if (rst_b2) left_b = 64;
    else if (left_b > 0) begin m_b[64 - left_b] = 16'h0; left_b--; end
    else if (clr_b) left_b = 64;
    else if (we_b) m_b[wa_b] = wd_b;
  endtask

  task automatic cycle();
    #1;
    if (chk_on) begin
      chk("busy_a", {63'h0, busy_a}, {63'h0, left_a > 0});
      chk("busy_b", {63'h0, busy_b}, {63'h0, left_b > 0});
      for (int p = 0; p < 2; p++)
        chk($sformatf("rd_a%0d", p), 64'(rd_a[p*32 +: 32]), 64'(exp_a(ra_a[p*5 +: 5])));
      for (int p = 0; p < 4; p++)
        chk($sformatf("rd_b%0d", p), 64'(rd_b[p*16 +: 16]), 64'(exp_b(ra_b[p*6 +: 6])));
    end
    @(posedge clock);
    model_edge();
    @(negedge clock);
  endtask

  task automatic rand_a(input bit allow_clr);
    we_a = 1'($urandom); wa_a = 5'($urandom); wd_a = $urandom; ra_a = 10'($urandom);
    clr_a = allow_clr && ($urandom_range(63) == 0);
  endtask

  task automatic rand_b(input bit allow_clr);
    we_b = 1'($urandom); wa_b = 6'($urandom); wd_b = 16'($urandom); ra_b = 24'($urandom);
    clr_b = allow_clr && ($urandom_range(63) == 0);
  endtask

  task automatic idle_a();
    we_a = 0; clr_a = 0; ra_a = 10'($urandom);
  endtask

  task automatic idle_b();
    we_b = 0; clr_b = 0; ra_b = 24'($urandom);
  endtask

  // Drive random traffic (including ignored clears/writes) while sweeping; count busy clocks.
  task automatic sweep_wait(output int na, output int nb);
    na = 0; nb = 0;
    for (int i = 0; i < 200 && (busy_a || busy_b); i++) begin
      if (busy_a) begin rand_a(1); na++; end else idle_a();
      if (busy_b) begin rand_b(1); nb++; end else idle_b();
      cycle();
    end
  endtask

  int na, nb;
  logic [5:0] r [4];

  initial begin
    rst_a = 1; rst_b2 = 1; clr_a = 0; clr_b = 0; we_a = 0; we_b = 0;
    wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0; ra_a = 0; ra_b = 0;
    for (int i = 0; i < 32; i++) m_a[i] = 32'h0;
    for (int i = 0; i < 64; i++) m_b[i] = 16'h0;
    @(negedge clock);
    cycle();
    chk_on = 1;
    cycle(); cycle();
    rst_a = 0; rst_b2 = 0;
    sweep_wait(na, nb);
    chk("sweep_len_a", 64'(na), 64'd32);
    chk("sweep_len_b", 64'(nb), 64'd64);

    // Preload junk, then reset again: the sweep must wipe it.
    for (int i = 0; i < 64; i++) begin
      if (i < 32) begin we_a = 1; wa_a = 5'(i); wd_a = 32'hDEADBEEF; end else idle_a();
      we_b = 1; wa_b = 6'(i); wd_b = 16'hBEEF; ra_b = 24'($urandom);
      cycle();
    end
    idle_a(); idle_b();
    #1 chk("preload_a", 64'(rd_a[31:0]), 64'(ra_a[4:0] == 0 ? 32'h0 : 32'hDEADBEEF));
    rst_a = 1; rst_b2 = 1;
    cycle(); cycle(); cycle();
    rst_a = 0; rst_b2 = 0;
    sweep_wait(na, nb);
    chk("resweep_len_a", 64'(na), 64'd32);
    chk("resweep_len_b", 64'(nb), 64'd64);
    for (int i = 0; i < 64; i++) begin
      idle_a(); idle_b();
      ra_a = {5'(31 - (i % 32)), 5'(i % 32)};
      ra_b = {6'(63 - i), 6'(i), 6'(i), 6'(i)};
      #1 chk("swept_b", 64'(rd_b[15:0]), 64'h0);
      cycle();
    end

    // Same-cycle write with read of the same address.
    we_a = 1; wa_a = 5; wd_a = 32'h12345678; ra_a = {5'd5, 5'd5};
    we_b = 1; wa_b = 5; wd_b = 16'h1234; ra_b = {18'h0, 6'd5};
    #1 chk("bypass_a", 64'(rd_a[31:0]), 64'h12345678);
    chk("nobypass_b_old", 64'(rd_b[15:0]), 64'h0);
    cycle();
    we_a = 0; we_b = 0;
    #1 chk("nobypass_b_new", 64'(rd_b[15:0]), 64'h1234);
    cycle();

    // Writes to entry 0.
    we_a = 1; wa_a = 0; wd_a = 32'hFFFFFFFF; ra_a = 10'd0;
    we_b = 1; wa_b = 0; wd_b = 16'hFFFF; ra_b = 24'd0;
    #1 chk("r0_same_a", 64'(rd_a[31:0]), 64'h0);
    cycle();
    we_a = 0; we_b = 0;
    #1 chk("r0_after_a", 64'(rd_a[31:0]), 64'h0);
    chk("r0_after_b", 64'(rd_b[15:0]), 64'hFFFF);
    cycle();

    // Clear together with a write: clear wins.
    we_a = 1; wa_a = 7; wd_a = 32'h11111111; cycle();
    clr_a = 1; we_a = 1; wa_a = 7; wd_a = 32'hA5A5A5A5;
    cycle();
    sweep_wait(na, nb);
    chk("clear_len_a", 64'(na), 64'd32);
    idle_a(); ra_a = {5'd7, 5'd7};
    #1 chk("clear_rf7_a", 64'(rd_a[31:0]), 64'h0);
    cycle();

    // Reset ten clocks into a sweep restarts it.
    clr_a = 1; cycle();
    for (int i = 0; i < 10; i++) begin rand_a(1); cycle(); end
    rst_a = 1; idle_a(); cycle();
    rst_a = 0;
    sweep_wait(na, nb);
    chk("restart_len_a", 64'(na), 64'd32);

    // Fill B with address values, then read with four ports at once.
    for (int i = 0; i < 64; i++) begin
      idle_a(); we_b = 1; wa_b = 6'(i); wd_b = 16'(i); cycle();
    end
    idle_b();
    for (int k = 0; k < 40; k++) begin
      for (int p = 0; p < 4; p++) r[p] = 6'($urandom);
      if (k % 4 == 0) r[3] = r[0];
      ra_b = {r[3], r[2], r[1], r[0]};
      idle_a();
      #1;
      for (int p = 0; p < 4; p++)
        chk($sformatf("addr_b%0d", p), 64'(rd_b[p*16 +: 16]), 64'(r[p]));
      if (k % 4 == 0) chk("dup_b", 64'(rd_b[63:48]), 64'(rd_b[15:0]));
      cycle();
    end

    // Free-running random traffic.
    for (int k = 0; k < 400; k++) begin
      rand_a(1); rand_b(1);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
